// File: rtl/ks_pkg.sv
// Shared definitions for the Kogge-Stone response checker.
//   KS_WIDTH   : default operand width of the adder under test
//   KS_CNT_W   : default width of the vector and error counters
//   KS_CNT_SAT : saturation value of a default-width counter
//   ks_state_e : checker run state
package ks_pkg;

    localparam int KS_WIDTH = 4;
    localparam int KS_CNT_W = 16;
    localparam logic [KS_CNT_W-1:0] KS_CNT_SAT = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ks_state_e;

endpackage

// File: rtl/ks_ref_adder.sv
// Golden reference adder: plain behavioural add, kept deliberately separate
// from any prefix-tree structure so it cannot share a bug with the adder
// under test.
//   a, b : WIDTH-bit operands
//   cin  : carry-in
//   sum  : WIDTH+1-bit result {cout, sum}
module ks_ref_adder
    import ks_pkg::*;
#(
    parameter int WIDTH = KS_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/ks_response_checker.sv
// Sequential response checker for a Kogge-Stone prefix adder.
// Vectors arrive on a valid/ready stream, are registered into stage 1 on
// accept and compared against a reference sum on the following edge.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : begin a run (honoured in IDLE or DONE only)
//   in_valid/in_ready  : vector handshake
//   a, b, cin          : operands applied to the adder under test
//   dut_sum, dut_cout  : result reported by the adder under test
//   busy, done, pass   : run status; pass meaningful only with done
//   vec_count          : vectors compared this run
//   err_count          : mismatches this run, saturating
//   fail_valid, fail_* : capture of the first failing vector
module ks_response_checker
    import ks_pkg::*;
#(
    parameter int WIDTH       = KS_WIDTH,
    parameter int NUM_VECTORS = 10,
    parameter int CNT_W       = KS_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH:0]   fail_exp,
    output logic [WIDTH:0]   fail_got
);

    localparam logic [CNT_W-1:0] NUM_V   = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == CNT_SAT) ? x : x + CNT_W'(1);
    endfunction

    ks_state_e        state;
    logic [CNT_W-1:0] acc_cnt;
    logic             accept;

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic             cin_p1;
    logic [WIDTH:0]   got_p1;
    logic [WIDTH:0]   exp_p1;

    assign in_ready = (state == ST_RUN) && (acc_cnt < NUM_V);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);
    assign pass     = done && (err_count == '0);

    // Stage 1: captured vector; data only loads on accept, so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1   <= a;
            b_p1   <= b;
            cin_p1 <= cin;
            got_p1 <= {dut_cout, dut_sum};
        end
    end

    ks_ref_adder #(.WIDTH(WIDTH)) u_ref (
        .a   (a_p1),
        .b   (b_p1),
        .cin (cin_p1),
        .sum (exp_p1)
    );

    // Stage 1 -> compare: counters, first-failure capture and run control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            acc_cnt    <= '0;
            vld_p1     <= 1'b0;
            vec_count  <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
        end else begin
            vld_p1 <= accept;

            if (vld_p1) begin
                vec_count <= vec_count + CNT_W'(1);
                if (exp_p1 != got_p1) begin
                    err_count <= sat_inc(err_count);
                    if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_a     <= a_p1;
                        fail_b     <= b_p1;
                        fail_exp   <= exp_p1;
                        fail_got   <= got_p1;
                    end
                end
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    // Stage 1 is always empty here, so the clear cannot
                    // collide with a compare in flight.
                    if (start) begin
                        state      <= (NUM_V == '0) ? ST_DRAIN : ST_RUN;
                        acc_cnt    <= '0;
                        vld_p1     <= 1'b0;
                        vec_count  <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_exp   <= '0;
                        fail_got   <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                        if (acc_cnt + CNT_W'(1) == NUM_V) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Wait until the last accepted vector has been compared.
                    if (!vld_p1) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ks_response_checker.sv
// Self-checking bench for ks_response_checker: directed and random runs
// against a vector-level reference model.
module tb_ks_response_checker;
    import ks_pkg::*;

    localparam int W  = 4;
    localparam int NV = 10;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, start_z;
    logic          in_valid;
    logic [W-1:0]  a, b, dut_sum;
    logic          cin, dut_cout;

    logic          in_ready, busy, done, pass, fail_valid;
    logic [CW-1:0] vec_count, err_count;
    logic [W-1:0]  fail_a, fail_b;
    logic [W:0]    fail_exp, fail_got;

    logic          in_ready_z, busy_z, done_z, pass_z, fail_valid_z;
    logic [CW-1:0] vec_count_z, err_count_z;
    logic [W-1:0]  fail_a_z, fail_b_z;
    logic [W:0]    fail_exp_z, fail_got_z;

    int n_vec  = 0;
    int n_miss = 0;

    // reference model state
    bit            m_active;
    int            m_acc, m_vec;
    logic [CW-1:0] m_err;
    bit            m_fail_valid;
    logic [W-1:0]  m_fail_a, m_fail_b;
    logic [W:0]    m_fail_exp, m_fail_got;

    always #5 clk = ~clk;

    ks_response_checker #(.WIDTH(W), .NUM_VECTORS(NV), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .cin(cin), .dut_sum(dut_sum),
        .dut_cout(dut_cout), .busy(busy), .done(done), .pass(pass),
        .vec_count(vec_count), .err_count(err_count), .fail_valid(fail_valid),
        .fail_a(fail_a), .fail_b(fail_b), .fail_exp(fail_exp), .fail_got(fail_got)
    );

    ks_response_checker #(.WIDTH(W), .NUM_VECTORS(0), .CNT_W(CW)) u_zero (
        .clk(clk), .rst_n(rst_n), .start(start_z), .in_valid(in_valid),
        .in_ready(in_ready_z), .a(a), .b(b), .cin(cin), .dut_sum(dut_sum),
        .dut_cout(dut_cout), .busy(busy_z), .done(done_z), .pass(pass_z),
        .vec_count(vec_count_z), .err_count(err_count_z), .fail_valid(fail_valid_z),
        .fail_a(fail_a_z), .fail_b(fail_b_z), .fail_exp(fail_exp_z), .fail_got(fail_got_z)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_acc = 0; m_vec = 0; m_err = '0;
        m_fail_valid = 0; m_fail_a = '0; m_fail_b = '0;
        m_fail_exp = '0; m_fail_got = '0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        check("in_ready_at_start", in_ready, m_active && (m_acc < NV));
        if (!m_active) begin
            model_clear();
            m_active = 1;
        end
    endtask

    task automatic send_vec(input logic v, input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic vci, input logic [W:0] vgot);
        bit rdy;
        int e;
        @(negedge clk);
        start    = 1'b0;
        in_valid = v;
        a        = va;
        b        = vb;
        cin      = vci;
        dut_sum  = vgot[W-1:0];
        dut_cout = vgot[W];
        rdy = m_active && (m_acc < NV);
        check("in_ready", in_ready, rdy);
        if (v && rdy) begin
            m_acc++;
            m_vec++;
            e = int'(va) + int'(vb) + int'(vci);
            if (e != int'(vgot)) begin
                if (m_err != KS_CNT_SAT) m_err++;
                if (!m_fail_valid) begin
                    m_fail_valid = 1;
                    m_fail_a     = va;
                    m_fail_b     = vb;
                    m_fail_exp   = e[W:0];
                    m_fail_got   = vgot;
                end
            end
        end
    endtask

    task automatic send_good(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vci);
        int e;
        e = int'(va) + int'(vb) + int'(vci);
        send_vec(1'b1, va, vb, vci, e[W:0]);
    endtask

    // random vector; roughly one in four reports a corrupted result
    task automatic send_rand(input logic v);
        logic [W-1:0] ra, rb;
        logic         rc;
        int           e;
        ra = W'($urandom);
        rb = W'($urandom);
        rc = 1'($urandom);
        e  = int'(ra) + int'(rb) + int'(rc);
        if ($urandom_range(3) == 0) e = e ^ (1 << $urandom_range(W));
        send_vec(v, ra, rb, rc, e[W:0]);
    endtask

    // exp_lat: edges from last accept to done, or -1 to skip that check
    task automatic finish_run(input string tag, input int exp_lat);
        int k;
        bit seen;
        seen = 0;
        k = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
            k = i;
            if (done) seen = 1;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        if (seen && exp_lat >= 0) check({tag, "_done_edges"}, k - 1, exp_lat);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_pass"}, pass, m_err == '0);
        check({tag, "_vec_count"}, vec_count, m_vec);
        check({tag, "_err_count"}, err_count, m_err);
        check({tag, "_fail_valid"}, fail_valid, m_fail_valid);
        check({tag, "_fail_a"}, fail_a, m_fail_a);
        check({tag, "_fail_b"}, fail_b, m_fail_b);
        check({tag, "_fail_exp"}, fail_exp, m_fail_exp);
        check({tag, "_fail_got"}, fail_got, m_fail_got);
        m_active = 0;
    endtask

    task automatic mid_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_outputs_zero"},
              {in_ready, busy, done, pass, vec_count, err_count, fail_valid,
               fail_a, fail_b, fail_exp, fail_got}, '0);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        m_active = 0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int a3;
        int guard;
        rst_n = 1'b1; start = 1'b0; start_z = 1'b0; in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        dut_sum = W'($urandom); dut_cout = 1'($urandom);
        m_active = 0;
        model_clear();

        // 1: asynchronous reset mid-cycle with random inputs
        repeat (2) @(posedge clk);
        in_valid = 1'b1;
        mid_reset("reset");
        check("reset_zero_dut", {in_ready_z, busy_z, done_z, pass_z, vec_count_z}, '0);
        in_valid = 1'b0;

        // 2: ten clean back-to-back vectors
        pulse_start();
        for (int i = 0; i < NV; i++) begin
            a3 = i + 1;
            send_good(W'(a3), W'(a3 + 2), 1'b0);
        end
        finish_run("clean", 2);

        // 3: vectors 3 and 7 wrong
        pulse_start();
        for (int i = 0; i < NV; i++) begin
            a3 = i + 1;
            if (i == 2)      send_vec(1'b1, W'(a3), W'(a3 + 2), 1'b0, 5'b01001);
            else if (i == 6) send_vec(1'b1, W'(a3), W'(a3 + 2), 1'b0, 5'b10001);
            else             send_good(W'(a3), W'(a3 + 2), 1'b0);
        end
        finish_run("two_err", 2);
        check("two_err_fail_exp_lit", fail_exp, 5'b01000);

        // 4: wrap-around carry-out
        pulse_start();
        send_vec(1'b1, 4'hF, 4'hF, 1'b1, 5'b11111);
        send_vec(1'b1, 4'hF, 4'h1, 1'b0, 5'b00000);
        for (int i = 2; i < NV; i++) send_good(W'($urandom), W'($urandom), 1'($urandom));
        finish_run("wrap", 2);
        check("wrap_fail_exp_lit", fail_exp, 5'b10000);

        // 5: gaps, start during RUN, in_valid held after the last accept
        pulse_start();
        for (int i = 0; i < NV; i++) begin
            send_rand(1'b1);
            if (i == 4) pulse_start();
            repeat (3) send_rand(1'b0);
        end
        repeat (5) send_rand(1'b1);
        finish_run("gaps", -1);

        // 6: reset after five accepts, then a clean run
        pulse_start();
        for (int i = 0; i < 5; i++) send_rand(1'b1);
        mid_reset("midrun");
        pulse_start();
        for (int i = 0; i < NV; i++) send_good(W'($urandom), W'($urandom), 1'($urandom));
        finish_run("after_reset", 2);

        // random runs with random gaps and corrupted results
        for (int r = 0; r < 3; r++) begin
            pulse_start();
            guard = 0;
            while (m_acc < NV && guard < 200) begin
                send_rand($urandom_range(9) < 7);
                guard++;
            end
            check("rand_accept_budget", m_acc, NV);
            finish_run("rand", -1);
        end

        // NUM_VECTORS = 0: start -> DRAIN -> DONE in two edges
        @(negedge clk);
        start_z = 1'b1;
        @(negedge clk);
        start_z = 1'b0;
        check("zero_busy", busy_z, 1'b1);
        check("zero_done_early", done_z, 1'b0);
        @(negedge clk);
        check("zero_done", done_z, 1'b1);
        check("zero_pass", pass_z, 1'b1);
        check("zero_vec_count", vec_count_z, '0);
        check("zero_err_count", err_count_z, '0);
        check("zero_capture",
              {in_ready_z, fail_valid_z, fail_a_z, fail_b_z, fail_exp_z, fail_got_z}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
